// File: rtl/output_periph_pkg.sv
// Shared types for the memory-mapped output bank:
// LCD strobe states, register kinds and LCD bit positions.
package output_periph_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD
    } lcd_state_e;

    typedef enum logic [2:0] {
        RK_NONE,
        RK_HEX,
        RK_LEDR,
        RK_LEDG,
        RK_LCD,
        RK_STATUS,
        RK_BLINK
    } reg_idx_e;

    localparam int LCD_ON_BIT    = 31;
    localparam int LCD_E_BIT     = 10;
    localparam int LCD_RS_BIT    = 9;
    localparam int LCD_RW_BIT    = 8;
    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_OVR_BIT  = 1;

    function automatic logic [31:0] bmerge(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  be
    );
        logic [31:0] r;
        for (int k = 0; k < 4; k++) begin
            r[8*k +: 8] = be[k] ? new_v[8*k +: 8] : old_v[8*k +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/lcd_strobe_fsm.sv
// LCD write sequencer: SETUP -> PULSE (E high) -> HOLD,
// one down-counter reloaded on every state entry.
module lcd_strobe_fsm
    import output_periph_pkg::*;
#(
    parameter int SETUP_CYC = 4,
    parameter int E_CYC     = 24
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic start_i,
    output logic e_o,
    output logic busy_o
);

    localparam int MAXC = (SETUP_CYC > E_CYC) ? SETUP_CYC : E_CYC;
    localparam int CW   = $clog2(MAXC + 1);

    lcd_state_e      r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_e;
    logic            r_busy;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_e     <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_state <= SETUP;
                        r_cnt   <= CW'(SETUP_CYC - 1);
                        r_busy  <= 1'b1;
                    end
                end
                SETUP: begin
                    if (r_cnt == '0) begin
                        r_state <= PULSE;
                        r_cnt   <= CW'(E_CYC - 1);
                        r_e     <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                PULSE: begin
                    if (r_cnt == '0) begin
                        r_state <= HOLD;
                        r_cnt   <= CW'(SETUP_CYC - 1);
                        r_e     <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (r_cnt == '0) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_e     <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign e_o    = r_e;
    assign busy_o = r_busy;

endmodule

// File: rtl/output_peripheral_v2.sv
// Memory-mapped HEX/LEDR/LEDG/LCD output bank with byte masks and LCD strobe.
// Optional HEX blink register enabled by OUTPUT_PERIPHERAL_BLINK_EN.
module output_peripheral_v2
    import output_periph_pkg::*;
#(
    parameter int          NUM_HEX      = 8,
    parameter int          HEX_W        = 7,
    parameter int          LEDR_W       = 17,
    parameter int          LEDG_W       = 8,
    parameter logic [11:0] BASE_ADDR    = 12'h800,
    parameter logic [11:0] STRIDE       = 12'h010,
    parameter int          LCD_SETUP    = 4,
    parameter int          LCD_E_CYCLES = 24,
    parameter int          BLINK_DIV    = 25_000_000
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      st_en_i,
    input  logic [11:0]               addr_i,
    input  logic [31:0]               st_data_i,
    input  logic [3:0]                bmask_i,
    output logic [NUM_HEX-1:0][31:0]  io_hex_o,
    output logic [31:0]               io_ledr_o,
    output logic [31:0]               io_ledg_o,
    output logic [31:0]               io_lcd_o,
    output logic                      lcd_busy_o,
    output logic [31:0]               ld_data_o
);

    localparam logic [HEX_W-1:0] HEX_BLANK = HEX_W'(7'h7F);

    function automatic logic [11:0] slot(input int j);
        return BASE_ADDR + STRIDE * 12'(j);
    endfunction

    logic [HEX_W-1:0]   r_hex [NUM_HEX];
    logic [LEDR_W-1:0]  r_ledr;
    logic [LEDG_W-1:0]  r_ledg;
    logic               r_lcd_on;
    logic               r_lcd_rs;
    logic               r_lcd_rw;
    logic [7:0]         r_lcd_data;
    logic               r_ovr;

    reg_idx_e           w_kind;
    logic [NUM_HEX-1:0] w_hex_hit;
    logic               w_e;
    logic               w_busy;
    logic               w_lcd_wr;
    logic               w_lcd_seq;
    logic               w_start;
    logic               w_ovr_set;
    logic               w_ovr_clr;
    logic               w_lcd_on_wr;
    logic [31:0]        w_lcd_word;
    logic [31:0]        w_status;
    logic [31:0]        w_rd;

    always_comb begin
        w_kind    = RK_NONE;
        w_hex_hit = '0;
        for (int i = 0; i < NUM_HEX; i++) begin
            if (addr_i == slot(i)) begin
                w_hex_hit[i] = 1'b1;
                w_kind       = RK_HEX;
            end
        end
        if (addr_i == slot(NUM_HEX))          w_kind = RK_LEDR;
        else if (addr_i == slot(NUM_HEX + 1)) w_kind = RK_LEDG;
        else if (addr_i == slot(NUM_HEX + 2)) w_kind = RK_LCD;
        else if (addr_i == slot(NUM_HEX + 3)) w_kind = RK_STATUS;
`ifdef OUTPUT_PERIPHERAL_BLINK_EN
        else if (addr_i == slot(NUM_HEX + 4)) w_kind = RK_BLINK;
`endif
    end

    // Bytes 0/1 carry DATA/RS/RW and start a strobe; an ON-only store does not.
    assign w_lcd_wr    = st_en_i && (w_kind == RK_LCD);
    assign w_lcd_seq   = w_lcd_wr && (|bmask_i[1:0]);
    assign w_start     = w_lcd_seq && !w_busy;
    assign w_ovr_set   = w_lcd_seq && w_busy;
    assign w_lcd_on_wr = w_lcd_wr && bmask_i[3] && !w_ovr_set;
    assign w_ovr_clr   = st_en_i && (w_kind == RK_STATUS)
                       && bmask_i[0] && st_data_i[STAT_OVR_BIT];

    lcd_strobe_fsm #(
        .SETUP_CYC (LCD_SETUP),
        .E_CYC     (LCD_E_CYCLES)
    ) u_lcd_fsm (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .start_i (w_start),
        .e_o     (w_e),
        .busy_o  (w_busy)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_HEX; i++) begin
                r_hex[i] <= HEX_BLANK;
            end
            r_ledr     <= '0;
            r_ledg     <= '0;
            r_lcd_on   <= 1'b0;
            r_lcd_rs   <= 1'b0;
            r_lcd_rw   <= 1'b0;
            r_lcd_data <= '0;
            r_ovr      <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_HEX; i++) begin
                if (st_en_i && w_hex_hit[i]) begin
                    r_hex[i] <= HEX_W'(bmerge(32'(r_hex[i]), st_data_i, bmask_i));
                end
            end
            if (st_en_i && (w_kind == RK_LEDR)) begin
                r_ledr <= LEDR_W'(bmerge(32'(r_ledr), st_data_i, bmask_i));
            end
            if (st_en_i && (w_kind == RK_LEDG)) begin
                r_ledg <= LEDG_W'(bmerge(32'(r_ledg), st_data_i, bmask_i));
            end
            if (w_start) begin
                if (bmask_i[0]) r_lcd_data <= st_data_i[7:0];
                if (bmask_i[1]) begin
                    r_lcd_rs <= st_data_i[LCD_RS_BIT];
                    r_lcd_rw <= st_data_i[LCD_RW_BIT];
                end
            end
            if (w_lcd_on_wr) r_lcd_on <= st_data_i[LCD_ON_BIT];
            if (w_ovr_set)      r_ovr <= 1'b1;
            else if (w_ovr_clr) r_ovr <= 1'b0;
        end
    end

`ifdef OUTPUT_PERIPHERAL_BLINK_EN
    localparam int BW = $clog2(BLINK_DIV + 1);

    logic [NUM_HEX-1:0] r_blink;
    logic [BW-1:0]      r_bcnt;
    logic               r_phase;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_blink <= '0;
            r_bcnt  <= '0;
            r_phase <= 1'b0;
        end else begin
            if (st_en_i && (w_kind == RK_BLINK)) begin
                r_blink <= NUM_HEX'(bmerge(32'(r_blink), st_data_i, bmask_i));
            end
            if (r_bcnt == BW'(BLINK_DIV - 1)) begin
                r_bcnt  <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_bcnt <= r_bcnt + 1'b1;
            end
        end
    end
`else
    logic w_unused_blink;
    assign w_unused_blink = (BLINK_DIV != 0);
`endif

    always_comb begin
        for (int i = 0; i < NUM_HEX; i++) begin
            io_hex_o[i] = 32'(r_hex[i]);
`ifdef OUTPUT_PERIPHERAL_BLINK_EN
            if (r_phase && r_blink[i]) io_hex_o[i] = 32'(HEX_BLANK);
`endif
        end
    end

    always_comb begin
        w_lcd_word             = '0;
        w_lcd_word[LCD_ON_BIT] = r_lcd_on;
        w_lcd_word[LCD_E_BIT]  = w_e;
        w_lcd_word[LCD_RS_BIT] = r_lcd_rs;
        w_lcd_word[LCD_RW_BIT] = r_lcd_rw;
        w_lcd_word[7:0]        = r_lcd_data;
    end

    always_comb begin
        w_status                = '0;
        w_status[STAT_BUSY_BIT] = w_busy;
        w_status[STAT_OVR_BIT]  = r_ovr;
    end

    always_comb begin
        w_rd = '0;
        case (w_kind)
            RK_HEX: begin
                for (int i = 0; i < NUM_HEX; i++) begin
                    if (w_hex_hit[i]) w_rd = 32'(r_hex[i]);
                end
            end
            RK_LEDR:   w_rd = 32'(r_ledr);
            RK_LEDG:   w_rd = 32'(r_ledg);
            RK_LCD:    w_rd = w_lcd_word;
            RK_STATUS: w_rd = w_status;
`ifdef OUTPUT_PERIPHERAL_BLINK_EN
            RK_BLINK:  w_rd = 32'(r_blink);
`endif
            default:   w_rd = '0;
        endcase
    end

    assign io_ledr_o  = 32'(r_ledr);
    assign io_ledg_o  = 32'(r_ledg);
    assign io_lcd_o   = w_lcd_word;
    assign lcd_busy_o = w_busy;
    assign ld_data_o  = w_rd;

endmodule

// File: tb/tb_output_peripheral_v2.sv
// Scoreboard bench for output_peripheral_v2 (default parameters, BLINK_DIV=4).
module tb_output_peripheral_v2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             st_en = 1'b0;
    logic [11:0]      addr = '0;
    logic [31:0]      wdata = '0;
    logic [3:0]       bmask = '0;
    logic [7:0][31:0] io_hex;
    logic [31:0]      io_ledr;
    logic [31:0]      io_ledg;
    logic [31:0]      io_lcd;
    logic             busy;
    logic [31:0]      ld;

    int               n_pass = 0;
    int               n_total = 0;
    logic [31:0]      exp_q[$];
    string            tag_q[$];

    output_peripheral_v2 #(.BLINK_DIV(4)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .st_en_i    (st_en),
        .addr_i     (addr),
        .st_data_i  (wdata),
        .bmask_i    (bmask),
        .io_hex_o   (io_hex),
        .io_ledr_o  (io_ledr),
        .io_ledg_o  (io_ledg),
        .io_lcd_o   (io_lcd),
        .lcd_busy_o (busy),
        .ld_data_o  (ld)
    );

    always #5 clk = ~clk;

    task automatic store(input logic [11:0] a, input logic [31:0] d,
                         input logic [3:0] m);
        @(negedge clk);
        addr  = a;
        wdata = d;
        bmask = m;
        st_en = 1'b1;
        @(posedge clk);
        #1;
        st_en = 1'b0;
        bmask = '0;
    endtask

    task automatic test_reset;
        logic [31:0] e;
        logic [31:0] got;
        string       t;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 13; i++) begin
            exp_q.push_back(i < 8 ? 32'h7F : 32'h0);
            tag_q.push_back($sformatf("reset_rd_%03h", 12'h800 + 12'(i * 16)));
        end
        for (int i = 0; i < 13; i++) begin
            addr = 12'h800 + 12'(i * 16);
            #1;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            n_total++;
            if (ld !== e) $display("FAIL %s: got %h expected %h", t, ld, e);
            else n_pass++;
        end
        addr = 12'h804;
        #1;
        n_total++;
        if (ld !== 32'h0) $display("FAIL unmapped_rd: got %h expected 0", ld);
        else n_pass++;
        got = {io_lcd[10], busy, io_hex[7][7:0], io_ledr[7:0]};
        n_total++;
        if (got !== {1'b0, 1'b0, 8'h7F, 8'h00})
            $display("FAIL reset_pins: got %h expected %h", got,
                     {1'b0, 1'b0, 8'h7F, 8'h00});
        else n_pass++;
    endtask

    task automatic test_bmask;
        logic [31:0] e;
        string       t;
        store(12'h880, 32'hDEADBEEF, 4'b0011);
        exp_q.push_back(32'h0000BEEF); tag_q.push_back("ledr_b01");
        addr = 12'h880; #1;
        e = exp_q.pop_front(); t = tag_q.pop_front();
        n_total++;
        if (ld !== e) $display("FAIL %s: got %h expected %h", t, ld, e);
        else n_pass++;
        store(12'h880, 32'hDEADBEEF, 4'b0100);
        exp_q.push_back(32'h0001BEEF); tag_q.push_back("ledr_b2");
        addr = 12'h880; #1;
        e = exp_q.pop_front(); t = tag_q.pop_front();
        n_total++;
        if (ld !== e || io_ledr !== e)
            $display("FAIL %s: got %h/%h expected %h", t, ld, io_ledr, e);
        else n_pass++;
        store(12'h884, 32'hFFFFFFFF, 4'b1111);
        store(12'h890, 32'hFFFFFFFF, 4'b1111);
        exp_q.push_back(32'h000000FF); tag_q.push_back("ledg_full");
        addr = 12'h890; #1;
        e = exp_q.pop_front(); t = tag_q.pop_front();
        n_total++;
        if (ld !== e || io_ledg !== e)
            $display("FAIL %s: got %h/%h expected %h", t, ld, io_ledg, e);
        else n_pass++;
        addr = 12'h880; #1;
        n_total++;
        if (ld !== 32'h0001BEEF)
            $display("FAIL unmapped_wr: got %h expected 0001beef", ld);
        else n_pass++;
        store(12'h830, 32'h12345678, 4'b0001);
        store(12'h830, 32'hFFFFFF00, 4'b1110);
        exp_q.push_back(32'h00000078); tag_q.push_back("hex3_mask");
        addr = 12'h830; #1;
        e = exp_q.pop_front(); t = tag_q.pop_front();
        n_total++;
        if (ld !== e || io_hex[3] !== e)
            $display("FAIL %s: got %h/%h expected %h", t, ld, io_hex[3], e);
        else n_pass++;
    endtask

    task automatic test_lcd_seq;
        logic [31:0] e;
        logic [31:0] got;
        store(12'h8A0, 32'h80000241, 4'b1111);
        for (int c = 1; c <= 34; c++) begin
            e = {19'd0, (c >= 1 && c <= 32), (c >= 5 && c <= 28), 1'b1, 10'h241};
            exp_q.push_back(e);
        end
        for (int c = 1; c <= 34; c++) begin
            @(negedge clk);
            got = {19'd0, busy, io_lcd[10], io_lcd[31], io_lcd[9:0]};
            e = exp_q.pop_front();
            n_total++;
            if (got !== e)
                $display("FAIL lcd_cycle_%0d: got %h expected %h", c, got, e);
            else n_pass++;
        end
        addr = 12'h8A0; #1;
        n_total++;
        if (ld !== 32'h80000241)
            $display("FAIL lcd_rd_idle: got %h expected 80000241", ld);
        else n_pass++;
    endtask

    task automatic test_overrun;
        int k;
        store(12'h8A0, 32'h80000241, 4'b1111);
        repeat (3) @(negedge clk);
        store(12'h8A0, 32'h00000055, 4'b1111);
        addr = 12'h8A0; #1;
        n_total++;
        if ({ld[31], ld[9:0]} !== {1'b1, 10'h241})
            $display("FAIL ovr_data_kept: got %h expected 80000241 (E ignored)", ld);
        else n_pass++;
        addr = 12'h8B0; #1;
        n_total++;
        if (ld !== 32'h3) $display("FAIL status_busy_ovr: got %h expected 3", ld);
        else n_pass++;
        k = 0;
        while (busy && k < 64) begin
            @(negedge clk);
            k++;
        end
        n_total++;
        if (busy) $display("FAIL idle_timeout: got busy=1 expected 0");
        else n_pass++;
        addr = 12'h8B0; #1;
        n_total++;
        if (ld !== 32'h2) $display("FAIL status_sticky: got %h expected 2", ld);
        else n_pass++;
        store(12'h8B0, 32'h2, 4'b0010);
        addr = 12'h8B0; #1;
        n_total++;
        if (ld !== 32'h2) $display("FAIL status_clr_nomask: got %h expected 2", ld);
        else n_pass++;
        store(12'h8B0, 32'h2, 4'b0001);
        addr = 12'h8B0; #1;
        n_total++;
        if (ld !== 32'h0) $display("FAIL status_w1c: got %h expected 0", ld);
        else n_pass++;
        store(12'h8A0, 32'h00000000, 4'b1000);
        @(negedge clk);
        addr = 12'h8A0; #1;
        n_total++;
        if (busy !== 1'b0 || ld !== 32'h00000241)
            $display("FAIL on_only: got busy=%b rd=%h expected busy=0 rd=00000241",
                     busy, ld);
        else n_pass++;
    endtask

    task automatic test_async_reset;
        int k;
        int e_cnt;
        int b_cnt;
        int first_e;
        store(12'h880, 32'h5, 4'b0001);
        store(12'h8A0, 32'h80000241, 4'b1111);
        k = 0;
        while (!io_lcd[10] && k < 40) begin
            @(negedge clk);
            k++;
        end
        n_total++;
        if (!io_lcd[10]) $display("FAIL e_rise_timeout: got E=0 expected 1");
        else n_pass++;
        repeat (5) @(negedge clk);
        addr = 12'h880;
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({io_lcd[10], busy, ld} !== {1'b0, 1'b0, 32'h0})
            $display("FAIL async_rst: got E=%b busy=%b ledr=%h expected 0/0/0",
                     io_lcd[10], busy, ld);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        store(12'h8A0, 32'h00000323, 4'b0011);
        e_cnt = 0;
        b_cnt = 0;
        first_e = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (io_lcd[10]) begin
                e_cnt++;
                if (first_e < 0) first_e = c;
            end
            if (busy) b_cnt++;
        end
        n_total++;
        if (e_cnt != 24 || b_cnt != 32 || first_e != 5)
            $display("FAIL post_rst_seq: got e=%0d busy=%0d first=%0d expected 24/32/5",
                     e_cnt, b_cnt, first_e);
        else n_pass++;
        n_total++;
        if (io_lcd !== 32'h00000323)
            $display("FAIL post_rst_lcd: got %h expected 00000323", io_lcd);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [31:0] e;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            addr  = 12'h800 + 12'(i * 16);
            wdata = 32'hAB00 | 32'(i * 9 + 1);
            bmask = 4'b1111;
            st_en = 1'b1;
            exp_q.push_back(32'(i * 9 + 1) & 32'h7F);
        end
        @(posedge clk);
        #1;
        st_en = 1'b0;
        bmask = '0;
        for (int i = 0; i < 8; i++) begin
            addr = 12'h800 + 12'(i * 16);
            #1;
            e = exp_q.pop_front();
            n_total++;
            if (ld !== e || io_hex[i] !== e)
                $display("FAIL b2b_hex%0d: got %h/%h expected %h", i, ld, io_hex[i], e);
            else n_pass++;
        end
    endtask

    task automatic test_blink;
        logic [31:0] v0;
        logic [31:0] v1;
        logic [31:0] e;
        int          k;
        store(12'h820, 32'h12, 4'b0001);
        store(12'h8C0, 32'h4, 4'b0001);
`ifdef OUTPUT_PERIPHERAL_BLINK_EN
        @(negedge clk);
        v0 = io_hex[2];
        k = 0;
        while (io_hex[2] === v0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        v0 = io_hex[2];
        n_total++;
        if (k >= 20 || (v0 !== 32'h12 && v0 !== 32'h7F))
            $display("FAIL blink_toggle: got %h expected alternation 12/7f", v0);
        else n_pass++;
        v1 = (v0 === 32'h12) ? 32'h7F : 32'h12;
        for (int t = 1; t < 12; t++) begin
            @(negedge clk);
            e = ((t / 4) % 2 == 0) ? v0 : v1;
            n_total++;
            if (io_hex[2] !== e)
                $display("FAIL blink_t%0d: got %h expected %h", t, io_hex[2], e);
            else n_pass++;
        end
        addr = 12'h8C0; #1;
        n_total++;
        if (ld !== 32'h4) $display("FAIL blink_rd: got %h expected 4", ld);
        else n_pass++;
`else
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            n_total++;
            if (io_hex[2] !== 32'h12)
                $display("FAIL noblink_t%0d: got %h expected 12", t, io_hex[2]);
            else n_pass++;
        end
        addr = 12'h8C0; #1;
        n_total++;
        if (ld !== 32'h0) $display("FAIL noblink_rd: got %h expected 0", ld);
        else n_pass++;
`endif
        addr = 12'h820; #1;
        n_total++;
        if (ld !== 32'h12) $display("FAIL blink_hex_rd: got %h expected 12", ld);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_bmask();
        test_lcd_seq();
        test_overrun();
        test_async_reset();
        test_back_to_back();
        test_blink();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before 1ms");
        $fatal(1);
    end

endmodule
